eth_rx_frame_chk: RTL and testbench

- Test-frame checker sitting directly downstream of the RX AXI-stream FIFO output (`rx_axis_fifo_*`, 8-bit) on the test port.
- Consumes frames produced by the test frame generator after the PHY/MAC loop.
- Verifies the header EtherType, the 16-bit sequence number and the incrementing payload pattern of every frame.
- Keeps frame and error statistics for AXI register readout and debug LED/ILA.

---
 rtl/eth_rx_frame_chk.sv | 150 +++++++++++++++
 tb/tb_eth_rx_frame_chk.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_chk.sv
// Test-frame checker on the RX stream: verifies EtherType, sequence continuity and
// the incrementing payload of each frame, and keeps frame/error statistics.
module eth_rx_frame_chk #(
  parameter logic [15:0] ETHTYPE = 16'h88B5,
  parameter int          MIN_LEN = 64,
  parameter int          MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clr,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic [31:0] frame_cnt,
  output logic [31:0] err_cnt,
  output logic        err,
  output logic [3:0]  err_flags,
  output logic [15:0] last_seq
);

  typedef enum logic [1:0] {S_HDR, S_SEQ, S_PAY, S_DROP} state_t;

  localparam logic [11:0] MIN_L = 12'(MIN_LEN);
  localparam logic [11:0] MAX_L = 12'(MAX_LEN);

  state_t      state_reg;
  logic [10:0] idx_reg;
  logic        synced_reg;
  logic [15:0] seq_reg;
  logic [15:0] exp_seq_reg;
  logic [7:0]  pay_exp_reg;
  logic        type_f_reg;
  logic        pay_f_reg;
  logic        fe_valid_reg;
  logic [3:0]  fe_flags_reg;
  logic        fe_has_seq_reg;
  logic [15:0] fe_seq_reg;

  logic        beat;
  logic        eof;
  logic        type_bad;
  logic        pay_bad;
  logic [15:0] seq_cur;
  logic [11:0] len;
  logic        has_seq;
  logic        len_bad;
  logic        seq_bad;
  logic [3:0]  frame_flags;
  logic [10:0] idx_sat;

  assign beat     = s_tvalid & s_tready;
  assign eof      = beat & s_tlast;
  assign idx_sat  = (idx_reg == 11'h7FF) ? idx_reg : idx_reg + 11'd1;
  assign type_bad = (state_reg == S_HDR) &&
                    (((idx_reg == 11'd12) && (s_tdata != ETHTYPE[15:8])) ||
                     ((idx_reg == 11'd13) && (s_tdata != ETHTYPE[7:0])));
  assign pay_bad  = (state_reg == S_PAY) && (s_tdata != pay_exp_reg);
  // A 16-byte frame ends on the low sequence byte, so it has to be taken from the bus.
  assign seq_cur  = ((state_reg == S_SEQ) && (idx_reg == 11'd15)) ?
                    {seq_reg[15:8], s_tdata} : seq_reg;
  assign len      = {1'b0, idx_reg} + 12'd1;
  assign has_seq  = (idx_reg >= 11'd15);
  assign len_bad  = (len < MIN_L) || (len > MAX_L);
  assign seq_bad  = synced_reg && has_seq && (seq_cur != exp_seq_reg);
  assign frame_flags = {pay_f_reg | pay_bad, seq_bad, type_f_reg | type_bad, len_bad};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_tready       <= 1'b0;
      frame_cnt      <= '0;
      err_cnt        <= '0;
      err            <= 1'b0;
      err_flags      <= '0;
      last_seq       <= '0;
      state_reg      <= S_HDR;
      idx_reg        <= '0;
      synced_reg     <= 1'b0;
      seq_reg        <= '0;
      exp_seq_reg    <= '0;
      pay_exp_reg    <= '0;
      type_f_reg     <= 1'b0;
      pay_f_reg      <= 1'b0;
      fe_valid_reg   <= 1'b0;
      fe_flags_reg   <= '0;
      fe_has_seq_reg <= 1'b0;
      fe_seq_reg     <= '0;
    end else begin
      s_tready     <= 1'b1;
      err          <= 1'b0;
      fe_valid_reg <= 1'b0;

      // Statistics commit one cycle after the frame end; clr always overrides it.
      if (clr) begin
        frame_cnt  <= '0;
        err_cnt    <= '0;
        err_flags  <= '0;
        last_seq   <= '0;
        synced_reg <= 1'b0;
      end else if (fe_valid_reg) begin
        if (frame_cnt != '1) frame_cnt <= frame_cnt + 32'd1;
        if (|fe_flags_reg) begin
          if (err_cnt != '1) err_cnt <= err_cnt + 32'd1;
          err       <= 1'b1;
          err_flags <= err_flags | fe_flags_reg;
        end
        if (fe_has_seq_reg) begin
          last_seq    <= fe_seq_reg;
          exp_seq_reg <= fe_seq_reg + 16'd1;
          synced_reg  <= 1'b1;
        end
      end

      if (eof) begin
        state_reg  <= S_HDR;
        idx_reg    <= '0;
        type_f_reg <= 1'b0;
        pay_f_reg  <= 1'b0;
        if (!clr && (state_reg != S_DROP)) begin
          fe_valid_reg   <= 1'b1;
          fe_flags_reg   <= frame_flags;
          fe_has_seq_reg <= has_seq;
          fe_seq_reg     <= seq_cur;
        end
      end else begin
        if (beat) begin
          idx_reg    <= idx_sat;
          type_f_reg <= type_f_reg | type_bad;
          pay_f_reg  <= pay_f_reg | pay_bad;
          case (state_reg)
            S_HDR: if (idx_reg == 11'd13) state_reg <= S_SEQ;
            S_SEQ: begin
              if (idx_reg == 11'd14) begin
                seq_reg[15:8] <= s_tdata;
              end else begin
                seq_reg[7:0] <= s_tdata;
                pay_exp_reg  <= s_tdata;
                state_reg    <= S_PAY;
              end
            end
            S_PAY:   pay_exp_reg <= pay_exp_reg + 8'd1;
            default: ;
          endcase
        end
        if (clr && (idx_reg != 11'd0)) state_reg <= S_DROP;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_chk.sv
// Randomized bench for eth_rx_frame_chk with a frame-level reference model.
module tb_eth_rx_frame_chk;

  localparam logic [15:0] ETHTYPE = 16'h88B5;
  localparam int          MIN_LEN = 64;
  localparam int          MAX_LEN = 1518;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [31:0] frame_cnt;
  logic [31:0] err_cnt;
  logic        err;
  logic [3:0]  err_flags;
  logic [15:0] last_seq;

  always #5 clk = ~clk;

  eth_rx_frame_chk #(.ETHTYPE(ETHTYPE), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .resetn(resetn), .clr(clr),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .err(err),
    .err_flags(err_flags), .last_seq(last_seq)
  );

  int n_chk = 0;
  int n_pass = 0;
  int err_seen = 0;

  // reference model state
  logic [31:0] m_frames, m_errs;
  logic [3:0]  m_flags;
  logic [15:0] m_last_seq, m_exp_seq;
  bit          m_synced;
  int          m_pulses = 0;
  logic [7:0]  fq[$];

  always @(negedge clk) if (err) err_seen++;

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_clear();
    m_frames = 0; m_errs = 0; m_flags = 0; m_last_seq = 0; m_synced = 0;
  endtask

  task automatic build_frame(input logic [15:0] seq, input int len, input logic [15:0] eth,
                             input int bad_idx, input logic [7:0] bad_val);
    logic [7:0] b;
    fq.delete();
    for (int i = 0; i < len; i++) begin
      if (i < 12)       b = 8'($urandom);
      else if (i == 12) b = eth[15:8];
      else if (i == 13) b = eth[7:0];
      else if (i == 14) b = seq[15:8];
      else if (i == 15) b = seq[7:0];
      else              b = 8'(int'(seq[7:0]) + i - 16);
      if (i == bad_idx) b = bad_val;
      fq.push_back(b);
    end
  endtask

  // Frame-level rules applied to the whole byte list at once.
  task automatic model_frame();
    int len;
    logic [3:0] f;
    logic [15:0] sq;
    len = fq.size();
    f = 4'b0000;
    sq = 16'h0000;
    if (len < MIN_LEN || len > MAX_LEN) f[0] = 1'b1;
    if (len > 12 && fq[12] != ETHTYPE[15:8]) f[1] = 1'b1;
    if (len > 13 && fq[13] != ETHTYPE[7:0]) f[1] = 1'b1;
    if (len >= 16) begin
      sq = {fq[14], fq[15]};
      if (m_synced && sq != m_exp_seq) f[2] = 1'b1;
      for (int k = 0; k < len - 16; k++)
        if (fq[16 + k] != 8'(int'(sq[7:0]) + k)) f[3] = 1'b1;
    end
    if (m_frames != 32'hFFFFFFFF) m_frames++;
    if (f != 4'b0000) begin
      if (m_errs != 32'hFFFFFFFF) m_errs++;
      m_pulses++;
      m_flags |= f;
    end
    if (len >= 16) begin
      m_last_seq = sq;
      m_exp_seq = sq + 16'd1;
      m_synced = 1'b1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".frame_cnt"}, frame_cnt, 32'd0);
    chk({tag, ".err_cnt"}, err_cnt, 32'd0);
    chk({tag, ".err_flags"}, {28'd0, err_flags}, 32'd0);
    chk({tag, ".last_seq"}, {16'd0, last_seq}, 32'd0);
  endtask

  task automatic send_frame(input int gap_max, input int clr_at, input int rst_at, output bit aborted);
    aborted = 1'b0;
    for (int i = 0; i < fq.size(); i++) begin
      if (gap_max > 0 && $urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, gap_max)) begin
          @(negedge clk);
          s_tvalid = 1'b0; s_tlast = 1'b0; clr = 1'b0;
        end
      end
      @(negedge clk);
      if (clr_at >= 0 && i == clr_at + 1) chk_zero("clr_mid");
      s_tvalid = 1'b1;
      s_tdata = fq[i];
      s_tlast = (i == fq.size() - 1);
      clr = (i == clr_at);
      if (i == clr_at) model_clear();
      if (i == rst_at) begin
        #2 resetn = 1'b0;
        #1;
        chk("rst_mid.s_tready", {31'd0, s_tready}, 32'd0);
        chk("rst_mid.err", {31'd0, err}, 32'd0);
        chk_zero("rst_mid");
        s_tvalid = 1'b0; s_tlast = 1'b0;
        model_clear();
        aborted = 1'b1;
        return;
      end
    end
  endtask

  task automatic end_and_check(input string tag, input int pulse);
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0; clr = 1'b0;
    if (pulse >= 0) chk({tag, ".err_pre"}, {31'd0, err}, 32'd0);
    @(negedge clk);
    if (pulse >= 0) chk({tag, ".err_pulse"}, {31'd0, err}, 32'(pulse));
    @(negedge clk);
    if (pulse >= 0) chk({tag, ".err_post"}, {31'd0, err}, 32'd0);
    chk({tag, ".frame_cnt"}, frame_cnt, m_frames);
    chk({tag, ".err_cnt"}, err_cnt, m_errs);
    chk({tag, ".err_flags"}, {28'd0, err_flags}, {28'd0, m_flags});
    chk({tag, ".last_seq"}, {16'd0, last_seq}, {16'd0, m_last_seq});
    chk({tag, ".err_pulses"}, 32'(err_seen), 32'(m_pulses));
    chk({tag, ".s_tready"}, {31'd0, s_tready}, 32'd1);
  endtask

  task automatic do_clr();
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    chk_zero("clr");
  endtask

  initial begin
    bit ab;
    int len, r, bad;
    logic [15:0] seq, eth;
    model_clear();
    m_exp_seq = 16'h0000;

    repeat (3) @(negedge clk);
    chk("rst.s_tready", {31'd0, s_tready}, 32'd0);
    chk("rst.err", {31'd0, err}, 32'd0);
    chk_zero("rst");
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_rel.s_tready", {31'd0, s_tready}, 32'd1);

    // sync and pass, back-to-back
    for (int s = 16'h0010; s <= 16'h0012; s++) begin
      build_frame(16'(s), 64, ETHTYPE, -1, 8'h00);
      model_frame();
      send_frame(0, -1, -1, ab);
    end
    end_and_check("sync", 0);

    // payload error at idx 20
    do_clr();
    build_frame(16'h0005, 64, ETHTYPE, 20, 8'h00);
    model_frame();
    send_frame(0, -1, -1, ab);
    end_and_check("pay", 1);

    // sequence wrap then gap
    do_clr();
    build_frame(16'hFFFF, 64, ETHTYPE, -1, 8'h00); model_frame(); send_frame(2, -1, -1, ab);
    end_and_check("seq_ffff", 0);
    build_frame(16'h0000, 64, ETHTYPE, -1, 8'h00); model_frame(); send_frame(2, -1, -1, ab);
    end_and_check("seq_0000", 0);
    build_frame(16'h0002, 64, ETHTYPE, -1, 8'h00); model_frame(); send_frame(2, -1, -1, ab);
    end_and_check("seq_0002", 1);

    // length and type
    do_clr();
    build_frame(16'h0100, 1519, ETHTYPE, -1, 8'h00); model_frame(); send_frame(0, -1, -1, ab);
    end_and_check("len_long", 1);
    build_frame(16'h7777, 10, ETHTYPE, -1, 8'h00); model_frame(); send_frame(0, -1, -1, ab);
    end_and_check("len_short", 1);
    build_frame(16'h0101, 64, 16'h0800, -1, 8'h00); model_frame(); send_frame(0, -1, -1, ab);
    end_and_check("type", 1);

    // clear mid-frame, then resync on a random sequence number
    build_frame(m_exp_seq, 64, ETHTYPE, -1, 8'h00); model_frame(); send_frame(0, -1, -1, ab);
    end_and_check("pre_clr", -1);
    build_frame(m_exp_seq, 64, ETHTYPE, -1, 8'h00);
    send_frame(0, 30, -1, ab);
    end_and_check("clr_drop", 0);
    build_frame(16'($urandom), 64, ETHTYPE, -1, 8'h00); model_frame(); send_frame(0, -1, -1, ab);
    end_and_check("clr_resync", 0);

    // asynchronous reset mid-frame
    build_frame(m_exp_seq, 64, ETHTYPE, -1, 8'h00);
    send_frame(0, -1, 40, ab);
    chk("rst_mid.aborted", {31'd0, ab}, 32'd1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_mid_rel.s_tready", {31'd0, s_tready}, 32'd1);
    build_frame(16'($urandom), 80, ETHTYPE, -1, 8'h00); model_frame(); send_frame(0, -1, -1, ab);
    end_and_check("rst_next", 0);

    // randomized frames with gaps, back-to-back runs and injected faults
    for (int f = 0; f < 40; f++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      len = $urandom_range(1, 15);
      else if (r == 1) len = $urandom_range(1400, 1530);
      else             len = $urandom_range(16, 200);
      seq = ($urandom_range(0, 4) == 0) ? 16'($urandom) : m_exp_seq;
      eth = ($urandom_range(0, 7) == 0) ? 16'h0800 : ETHTYPE;
      bad = -1;
      if (len > 16 && $urandom_range(0, 5) == 0) bad = $urandom_range(16, len - 1);
      build_frame(seq, len, eth, bad, 8'(int'(seq[7:0]) + bad - 16) ^ 8'($urandom_range(1, 255)));
      model_frame();
      send_frame(3, -1, -1, ab);
      if ($urandom_range(0, 2) != 0) end_and_check("rand", -1);
    end
    end_and_check("rand_end", -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
